// File: rtl/uart_sched_pkg.sv
// Shared types and default constants for the UART transmit-buffer read scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam int NCH_DEF      = 5;
    localparam int WORDS_DEF    = 18;
    localparam int SLOT_DEF     = 64;
    localparam int RD_START_DEF = 40;
    localparam int RD_LEN_DEF   = 4;
    localparam int AW_DEF       = 5;

endpackage

// File: rtl/uart_rd_sched_if.sv
// Bundle between the read scheduler, the strobe sources and the buffer RAM / serializers.
interface uart_rd_sched_if
    import uart_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF,
    parameter int CW  = $clog2(NCH)
);
    logic [NCH-1:0] strobe;
    logic [AW-1:0]  rd_adr;
    logic [CW-1:0]  rd_ch;
    logic           rd;
    logic [NCH-1:0] rd_sel;
    logic [NCH-1:0] done;
    logic           busy;

    modport master (
        input  strobe,
        output rd_adr, rd_ch, rd, rd_sel, done, busy
    );

    modport slave (
        output strobe,
        input  rd_adr, rd_ch, rd, rd_sel, done, busy
    );
endinterface

// File: rtl/uart_rd_sched_rr_arbiter.sv
// Picks the next channel from the eligible set; round-robin after `last`, or
// fixed lowest-index priority when UART_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
    parameter int NCH = 5,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  last,
    output logic [CW-1:0]  winner,
    output logic           valid
);

`ifdef UART_SCHED_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = CW'(i);
                valid  = 1'b1;
            end
        end
    end
`else
    int idx;

    // Walk from the farthest candidate to the nearest so the one right after last wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(last) + i) % NCH;
            if (req[idx]) begin
                winner = CW'(idx);
                valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_rd_sched.sv
// Shared read-port scheduler: grants one UART channel at a time and walks the
// frame's word addresses with a fixed-length slot per word. Arbitration mode: UART_SCHED_FIXED_PRIO_EN.
module uart_rd_sched
    import uart_sched_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int WORDS    = WORDS_DEF,
    parameter int SLOT     = SLOT_DEF,
    parameter int RD_START = RD_START_DEF,
    parameter int RD_LEN   = RD_LEN_DEF,
    parameter int AW       = AW_DEF,
    parameter int CW       = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    uart_rd_sched_if.master bus
);

    localparam int SW = $clog2(SLOT);

    state_t         state;
    logic [NCH-1:0] s1, ss, served, active, eligible, served_set;
    logic [SW-1:0]  slot_cnt;
    logic [AW-1:0]  word;
    logic [CW-1:0]  ch, last, win;
    logic           win_vld;
    logic           rd, busy;
    logic [NCH-1:0] rd_sel, done;

    function automatic logic in_win(input int c);
        return (c >= RD_START) && (c <= RD_START + RD_LEN - 1);
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] c);
        return NCH'(1) << c;
    endfunction

    always_comb begin
        active = '0;
        if (state != IDLE)
            active[ch] = 1'b1;
    end

    assign served_set = (state == DONE) ? onehot(ch) : '0;
    assign eligible   = ss & ~served;

    // served drops only once the strobe is low and the channel is not mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= '0;
            ss     <= '0;
            served <= '0;
        end else begin
            s1     <= bus.strobe;
            ss     <= s1;
            served <= (served & (ss | active)) | served_set;
        end
    end

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .req    (eligible),
        .last   (last),
        .winner (win),
        .valid  (win_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            slot_cnt <= '0;
            word     <= '0;
            ch       <= '0;
            last     <= CW'(NCH - 1);
            rd       <= 1'b0;
            rd_sel   <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (win_vld) begin
                        state    <= BURST;
                        ch       <= win;
                        slot_cnt <= '0;
                        word     <= '0;
                        busy     <= 1'b1;
                        rd       <= in_win(0);
                        rd_sel   <= in_win(0) ? onehot(win) : '0;
                    end
                end
                BURST: begin
                    if (slot_cnt == SW'(SLOT - 1)) begin
                        slot_cnt <= '0;
                        if (word < AW'(WORDS - 1)) begin
                            word   <= word + AW'(1);
                            rd     <= in_win(0);
                            rd_sel <= in_win(0) ? onehot(ch) : '0;
                        end else begin
                            state  <= DONE;
                            word   <= '0;
                            rd     <= 1'b0;
                            rd_sel <= '0;
                            done   <= onehot(ch);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + SW'(1);
                        rd       <= in_win(int'(slot_cnt) + 1);
                        rd_sel   <= in_win(int'(slot_cnt) + 1) ? onehot(ch) : '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    last  <= ch;
                    ch    <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_adr = word;
    assign bus.rd_ch  = ch;
    assign bus.rd     = rd;
    assign bus.rd_sel = rd_sel;
    assign bus.done   = done;
    assign bus.busy   = busy;

endmodule
